siso_shift_ctrl: RTL and testbench

SISO_SHIFT_CTRL -- requirements
Module: siso_shift_ctrl

---
 rtl/siso_shift_if.sv | 25 ++
 rtl/siso_shift_ctrl.sv | 101 ++++++++++
 tb/tb_siso_shift_ctrl.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/siso_shift_if.sv
// Handshake and serial-output bundle for the SISO shift controller.
// The slave modport is the controller side; the master modport drives words in.
interface siso_shift_if #(
   parameter int unsigned WIDTH = 8
);
   logic [WIDTH-1:0] din;
   logic             din_valid;
   logic             din_ready;
   logic             stall;
   logic             abort;
   logic             sout;
   logic             sout_valid;
   logic             busy;
   logic             done;

   modport master (
      output din, din_valid, stall, abort,
      input  din_ready, sout, sout_valid, busy, done
   );

   modport slave (
      input  din, din_valid, stall, abort,
      output din_ready, sout, sout_valid, busy, done
   );
endinterface

// File: rtl/siso_shift_ctrl.sv
// Parallel-in serial-out word serializer with stall, abort and a one-cycle done pulse.
// Outputs are decoded from registered state; sout_valid additionally masks with stall.
module siso_shift_ctrl #(
   parameter int unsigned WIDTH     = 8,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic        Clk,
   input  logic        rst,
   siso_shift_if.slave bus
);

   localparam int unsigned       CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   shreg_q, shreg_d;
   logic [CNT_W-1:0]   cnt_q,   cnt_d;

   // State and datapath registers
   always_ff @(posedge Clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         shreg_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state and datapath update
   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.din_valid) begin
               state_d = ST_SHIFT;
               shreg_d = bus.din;
               cnt_d   = '0;
            end
         end
         ST_SHIFT: begin
            // abort outranks stall; the partially sent word is dropped
            if (bus.abort) begin
               state_d = ST_IDLE;
               shreg_d = '0;
               cnt_d   = '0;
            end else if (!bus.stall) begin
               if (MSB_FIRST) shreg_d = shreg_q << 1;
               else           shreg_d = shreg_q >> 1;
               if (cnt_q == LAST_CNT) begin
                  state_d = ST_DONE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            shreg_d = '0;
            cnt_d   = '0;
         end
      endcase
   end

   // Output decode
   always_comb begin
      bus.din_ready  = 1'b0;
      bus.sout       = 1'b0;
      bus.sout_valid = 1'b0;
      bus.busy       = 1'b0;
      bus.done       = 1'b0;
      case (state_q)
         ST_IDLE: bus.din_ready = 1'b1;
         ST_SHIFT: begin
            bus.busy       = 1'b1;
            bus.sout       = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
            bus.sout_valid = !bus.stall;
         end
         ST_DONE: begin
            bus.busy = 1'b1;
            bus.done = 1'b1;
         end
         default: bus.din_ready = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_siso_shift_ctrl.sv
// Directed bench for siso_shift_ctrl: one MSB-first and one LSB-first instance,
// checked every cycle against a word/bit-index model plus literal per-scenario results.
module tb_siso_shift_ctrl;

   localparam int unsigned W = 8;

   logic Clk = 1'b0;
   logic rst = 1'b0;
   always #5 Clk = ~Clk;

   logic [W-1:0] din_i [2];
   logic         dv_i;
   logic         stall_i;
   logic         abort_i;

   logic rdy_o [2];
   logic so_o  [2];
   logic sv_o  [2];
   logic bsy_o [2];
   logic dn_o  [2];

   siso_shift_if #(.WIDTH(W)) if_m ();
   siso_shift_if #(.WIDTH(W)) if_l ();

   siso_shift_ctrl #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (.Clk(Clk), .rst(rst), .bus(if_m));
   siso_shift_ctrl #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (.Clk(Clk), .rst(rst), .bus(if_l));

   assign if_m.din       = din_i[0];
   assign if_m.din_valid = dv_i;
   assign if_m.stall     = stall_i;
   assign if_m.abort     = abort_i;
   assign if_l.din       = din_i[1];
   assign if_l.din_valid = dv_i;
   assign if_l.stall     = stall_i;
   assign if_l.abort     = abort_i;

   assign rdy_o[0] = if_m.din_ready;
   assign so_o[0]  = if_m.sout;
   assign sv_o[0]  = if_m.sout_valid;
   assign bsy_o[0] = if_m.busy;
   assign dn_o[0]  = if_m.done;
   assign rdy_o[1] = if_l.din_ready;
   assign so_o[1]  = if_l.sout;
   assign sv_o[1]  = if_l.sout_valid;
   assign bsy_o[1] = if_l.busy;
   assign dn_o[1]  = if_l.done;

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input int idx, input int got, input int want);
      checks = checks + 1;
      if (got !== want) begin
         errors = errors + 1;
         $display("FAIL %s dut%0d t=%0t got=%0h want=%0h", name, idx, $time, got, want);
      end
   endtask

   // Model: a word in flight is (word, k); k = bits already consumed, k == W is the done cycle
   logic [W-1:0] m_word [2];
   int           m_k    [2];
   bit           m_act  [2];

   initial begin
      for (int i = 0; i < 2; i++) begin
         m_word[i] = '0;
         m_k[i]    = 0;
         m_act[i]  = 1'b0;
      end
   end

   always @(posedge Clk or posedge rst) begin
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            m_act[i] = 1'b0;
            m_k[i]   = 0;
         end else if (!m_act[i]) begin
            if (dv_i) begin
               m_act[i]  = 1'b1;
               m_word[i] = din_i[i];
               m_k[i]    = 0;
            end
         end else if (m_k[i] == W) begin
            m_act[i] = 1'b0;
         end else if (abort_i) begin
            m_act[i] = 1'b0;
         end else if (!stall_i) begin
            m_k[i] = m_k[i] + 1;
         end
      end
   end

   // Per-cycle compare plus serial-bit recorder
   logic [W-1:0] rec  [2];
   int           nval [2];
   initial begin
      rec[0] = '0; rec[1] = '0; nval[0] = 0; nval[1] = 0;
   end

   always @(negedge Clk) begin
      for (int i = 0; i < 2; i++) begin
         logic e_rdy, e_so, e_sv, e_bsy, e_dn;
         int   bi;
         e_rdy = 1'b1; e_so = 1'b0; e_sv = 1'b0; e_bsy = 1'b0; e_dn = 1'b0;
         if (m_act[i]) begin
            e_rdy = 1'b0;
            e_bsy = 1'b1;
            if (m_k[i] == W) begin
               e_dn = 1'b1;
            end else begin
               bi   = (i == 0) ? (W - 1 - m_k[i]) : m_k[i];
               e_so = m_word[i][bi];
               e_sv = !stall_i;
            end
         end
         if (chk_en) begin
            chk("din_ready",  i, int'(rdy_o[i]), int'(e_rdy));
            chk("sout",       i, int'(so_o[i]),  int'(e_so));
            chk("sout_valid", i, int'(sv_o[i]),  int'(e_sv));
            chk("busy",       i, int'(bsy_o[i]), int'(e_bsy));
            chk("done",       i, int'(dn_o[i]),  int'(e_dn));
         end
         if (sv_o[i] === 1'b1) begin
            rec[i]  = {rec[i][W-2:0], so_o[i]};
            nval[i] = nval[i] + 1;
         end
      end
   end

   // One word: ss/sl = stall window, ac = abort cycle, rc = reset cycle, iv = ignored din_valid cycle
   task automatic run_word(input logic [W-1:0] w0, input logic [W-1:0] w1,
                           input int ss, input int sl, input int ac, input int rc,
                           input int iv, output int n);
      n = 0;
      @(posedge Clk); #2;
      din_i[0] = w0; din_i[1] = w1; dv_i = 1'b1;
      @(posedge Clk); #2;
      dv_i = 1'b0;
      for (int c = 1; c <= 16; c++) begin
         stall_i = (ss > 0) && (c >= ss) && (c < ss + sl);
         abort_i = (c == ac);
         if (iv > 0 && (c == iv || c == iv + 1)) begin
            din_i[0] = 8'h5A; din_i[1] = 8'h5A; dv_i = 1'b1;
         end else begin
            dv_i = 1'b0;
         end
         if (c == rc) begin
            rst = 1'b1;
            #1;
            chk("async_rst_ready", 0, int'(rdy_o[0]), 1);
            chk("async_rst_busy",  0, int'(bsy_o[0]), 0);
            chk("async_rst_sv",    1, int'(sv_o[1]),  0);
            #1 rst = 1'b0;
         end
         @(negedge Clk);
         if (dn_o[0] === 1'b1) begin
            n = c;
            break;
         end
         @(posedge Clk); #2;
      end
      stall_i = 1'b0; abort_i = 1'b0; dv_i = 1'b0;
   endtask

   int n;
   int v0, v1;

   initial begin
      din_i[0] = 8'hAA; din_i[1] = 8'hAA;
      dv_i = 1'b1; stall_i = 1'b0; abort_i = 1'b0;
      #1 rst = 1'b1;
      #1;
      chk("rst_ready", 0, int'(rdy_o[0]), 1);
      chk("rst_sout",  0, int'(so_o[0]),  0);
      chk("rst_sv",    0, int'(sv_o[0]),  0);
      chk("rst_busy",  1, int'(bsy_o[1]), 0);
      chk("rst_done",  1, int'(dn_o[1]),  0);
      chk_en = 1'b1;
      #9;
      rst = 1'b0; dv_i = 1'b0;

      // Basic word, both bit orders
      v0 = nval[0]; v1 = nval[1];
      run_word(8'hA5, 8'h01, 0, 0, 0, 0, 0, n);
      chk("basic_done_cycle", 0, n, 9);
      chk("basic_bits",       0, int'(rec[0]), 32'hA5);
      chk("lsb_bits",         1, int'(rec[1]), 32'h80);
      chk("basic_nvalid",     0, nval[0] - v0, 8);
      chk("lsb_nvalid",       1, nval[1] - v1, 8);

      // Three-cycle stall after the 2nd bit
      v0 = nval[0]; v1 = nval[1];
      run_word(8'hF0, 8'hF0, 3, 3, 0, 0, 0, n);
      chk("stall_done_cycle", 0, n, 12);
      chk("stall_bits",       0, int'(rec[0]), 32'hF0);
      chk("stall_lsb_bits",   1, int'(rec[1]), 32'h0F);
      chk("stall_nvalid",     0, nval[0] - v0, 8);

      // Abort with stall at the 4th bit; din_valid mid-word must be ignored
      v0 = nval[0];
      run_word(8'hFF, 8'hFF, 4, 1, 4, 0, 2, n);
      chk("abort_no_done",  0, n, 0);
      chk("abort_nvalid",   0, nval[0] - v0, 3);
      chk("abort_bits",     0, int'(rec[0][2:0]), 7);

      // Reset during the 5th bit, then a clean word
      v0 = nval[0];
      run_word(8'h3C, 8'h3C, 0, 0, 0, 5, 0, n);
      chk("rst_mid_no_done", 0, n, 0);
      chk("rst_mid_nvalid",  0, nval[0] - v0, 4);
      chk("rst_mid_bits",    0, int'(rec[0][3:0]), 3);
      chk("rst_mid_lsb_bits", 1, int'(rec[1][3:0]), 3);
      run_word(8'h81, 8'h81, 0, 0, 0, 0, 0, n);
      chk("after_rst_done_cycle", 0, n, 9);
      chk("after_rst_bits",       0, int'(rec[0]), 32'h81);
      chk("after_rst_lsb_bits",   1, int'(rec[1]), 32'h81);

      repeat (3) @(posedge Clk);
      @(negedge Clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
